// File: rtl/ecc_codec_engine_if.sv
// Purpose: bundles the job request inputs and result outputs of the SECDED codec engine.
// Latency: none, wiring only.
// Backpressure: none; a job is launched by a start rising edge and reported by a one-cycle done pulse.
// Signals: start, CTRL, DATA_IN, CODEWORD_WIDTH, NOISE (register file -> engine);
//          data_out, operation_done, num_of_errors, err_count (engine -> system).
// err_count exists only when ECC_ERR_CNT_EN is defined.
interface ecc_codec_engine_if #(
    parameter int AMBA_WORD = 32
);
    logic                 start;
    logic [AMBA_WORD-1:0] CTRL;
    logic [AMBA_WORD-1:0] DATA_IN;
    logic [AMBA_WORD-1:0] CODEWORD_WIDTH;
    logic [AMBA_WORD-1:0] NOISE;
    logic [AMBA_WORD-1:0] data_out;
    logic                 operation_done;
    logic [1:0]           num_of_errors;
`ifdef ECC_ERR_CNT_EN
    logic [15:0]          err_count;
`endif

    // register-file side
    modport master (
        output start, CTRL, DATA_IN, CODEWORD_WIDTH, NOISE,
        input  data_out, operation_done, num_of_errors
`ifdef ECC_ERR_CNT_EN
        , input err_count
`endif
    );

    // engine side
    modport slave (
        input  start, CTRL, DATA_IN, CODEWORD_WIDTH, NOISE,
        output data_out, operation_done, num_of_errors
`ifdef ECC_ERR_CNT_EN
        , output err_count
`endif
    );
endinterface

// File: rtl/ecc_codec_engine.sv
// Purpose: extended-Hamming (SECDED) encode / decode / full-channel job engine, n = 8/16/32.
// Latency: done pulse in the 2nd cycle after the launch edge (encode/decode), 4th cycle (full channel).
// Backpressure: none; start edges seen outside IDLE are dropped, results held until the next done.
// Ports: clk, rst (async, active-low); bus (ecc_codec_engine_if.slave) carries start, CTRL,
//        DATA_IN, CODEWORD_WIDTH, NOISE in and data_out, operation_done, num_of_errors out.
// Optional: define ECC_ERR_CNT_EN to add the saturating 16-bit err_count output.
module ecc_codec_engine #(
    parameter int AMBA_WORD  = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    ecc_codec_engine_if.slave    bus
);
    localparam int SW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_ENC, S_CHAN, S_DEC, S_DONE} state_t;

    localparam logic [1:0] OP_ENC  = 2'b00;
    localparam logic [1:0] OP_DEC  = 2'b01;
    localparam logic [1:0] OP_ILL  = 2'b11;

    // codeword length selected by CODEWORD_WIDTH[1:0]
    function automatic int f_n(input logic [1:0] w);
        case (w)
            2'b00:   return 8;
            2'b01:   return 16;
            default: return DATA_WIDTH;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_mask(input int n);
        logic [DATA_WIDTH-1:0] m;
        for (int i = 0; i < DATA_WIDTH; i++) m[i] = (i < n);
        return m;
    endfunction

    // Payload fills non-power-of-two Hamming positions; bit n-1 is overall parity.
    function automatic logic [DATA_WIDTH-1:0] f_encode(input logic [DATA_WIDTH-1:0] d, input int n);
        logic [DATA_WIDTH-1:0] cw;
        logic p;
        int   k;
        cw = '0;
        k  = 0;
        for (int pos = 1; pos < DATA_WIDTH; pos++) begin
            if (pos < n && (pos & (pos - 1)) != 0) begin
                cw[SW'(pos - 1)] = d[SW'(k)];
                k++;
            end
        end
        // parity positions are still zero here, so they do not pollute each other
        for (int b = 0; b < SW; b++) begin
            p = 1'b0;
            for (int pos = 1; pos < DATA_WIDTH; pos++)
                if (pos < n && pos[b]) p ^= cw[SW'(pos - 1)];
            if ((1 << b) < n) cw[SW'((1 << b) - 1)] = p;
        end
        cw[SW'(n - 1)] = ^cw;
        return cw;
    endfunction

    function automatic logic [SW-1:0] f_syndrome(input logic [DATA_WIDTH-1:0] cw, input int n);
        logic [SW-1:0] s;
        s = '0;
        for (int pos = 1; pos < DATA_WIDTH; pos++)
            if (pos < n && cw[SW'(pos - 1)]) s ^= SW'(pos);
        return s;
    endfunction

    function automatic logic [1:0] f_dec_nerr(input logic [DATA_WIDTH-1:0] cw, input int n);
        logic [SW-1:0] s;
        s = f_syndrome(cw, n);
        if (!(^cw))          return (s == '0) ? 2'd0 : 2'd2;
        if (int'(s) >= n)    return 2'd2;   // points past the codeword: cannot be a single error
        return 2'd1;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_dec_payload(input logic [DATA_WIDTH-1:0] cw, input int n);
        logic [SW-1:0]         s;
        logic [DATA_WIDTH-1:0] c;
        logic [DATA_WIDTH-1:0] pl;
        int                    k;
        s  = f_syndrome(cw, n);
        c  = cw;
        pl = '0;
        k  = 0;
        // s==0 with odd parity is an overall-parity-bit error: payload untouched
        if ((^cw) && s != '0 && int'(s) < n) c[SW'(int'(s) - 1)] = ~c[SW'(int'(s) - 1)];
        for (int pos = 1; pos < DATA_WIDTH; pos++) begin
            if (pos < n && (pos & (pos - 1)) != 0) begin
                pl[SW'(k)] = c[SW'(pos - 1)];
                k++;
            end
        end
        return pl;
    endfunction

    state_t                r_state;
    logic                  r_start_q;
    logic [1:0]            r_op;
    logic [1:0]            r_wsel;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_noise;
    logic [DATA_WIDTH-1:0] r_cw;
    logic [AMBA_WORD-1:0]  r_data_out;
    logic [1:0]            r_nerr;
`ifdef ECC_ERR_CNT_EN
    logic [15:0]           r_err_cnt;
`endif

    int                    w_n;
    logic [DATA_WIDTH-1:0] w_mask;
    logic [DATA_WIDTH-1:0] w_enc_cw;
    logic [DATA_WIDTH-1:0] w_dec_in;
    logic [DATA_WIDTH-1:0] w_dec_pl;
    logic [1:0]            w_dec_ne;
    logic                  w_launch;
    logic                  w_unused;

    assign w_launch = bus.start && !r_start_q;
    // only the low bits of the control words carry meaning
    assign w_unused = ^{bus.CTRL, bus.CODEWORD_WIDTH, bus.DATA_IN, bus.NOISE};

    always_comb begin
        w_n      = f_n(r_wsel);
        w_mask   = f_mask(w_n);
        w_enc_cw = f_encode(r_data, w_n);
        // decode jobs land the raw DATA_IN in r_cw, so mask here
        w_dec_in = r_cw & w_mask;
        w_dec_pl = f_dec_payload(w_dec_in, w_n);
        w_dec_ne = f_dec_nerr(w_dec_in, w_n);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_start_q  <= 1'b0;
            r_op       <= OP_ENC;
            r_wsel     <= 2'b00;
            r_data     <= '0;
            r_noise    <= '0;
            r_cw       <= '0;
            r_data_out <= '0;
            r_nerr     <= 2'd0;
`ifdef ECC_ERR_CNT_EN
            r_err_cnt  <= 16'd0;
`endif
        end else begin
            r_start_q <= bus.start;
            case (r_state)
                S_IDLE: begin
                    // illegal op consumes the edge and leaves everything as is
                    if (w_launch && bus.CTRL[1:0] != OP_ILL) begin
                        r_op    <= bus.CTRL[1:0];
                        r_wsel  <= bus.CODEWORD_WIDTH[1:0];
                        r_data  <= bus.DATA_IN[DATA_WIDTH-1:0];
                        r_noise <= bus.NOISE[DATA_WIDTH-1:0];
                        r_cw    <= bus.DATA_IN[DATA_WIDTH-1:0];
                        r_state <= (bus.CTRL[1:0] == OP_DEC) ? S_DEC : S_ENC;
                    end
                end
                S_ENC: begin
                    r_cw <= w_enc_cw;
                    if (r_op == OP_ENC) begin
                        r_data_out <= AMBA_WORD'(w_enc_cw);
                        r_nerr     <= 2'd0;
                        r_state    <= S_DONE;
                    end else begin
                        r_state    <= S_CHAN;
                    end
                end
                S_CHAN: begin
                    r_cw    <= r_cw ^ (r_noise & w_mask);
                    r_state <= S_DEC;
                end
                S_DEC: begin
                    r_data_out <= AMBA_WORD'(w_dec_pl);
                    r_nerr     <= w_dec_ne;
`ifdef ECC_ERR_CNT_EN
                    if (w_dec_ne != 2'd0 && r_err_cnt != 16'hFFFF)
                        r_err_cnt <= r_err_cnt + 16'd1;
`endif
                    r_state    <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.data_out       = r_data_out;
    assign bus.num_of_errors  = r_nerr;
    assign bus.operation_done = (r_state == S_DONE);
`ifdef ECC_ERR_CNT_EN
    assign bus.err_count      = r_err_cnt;
`endif
endmodule
